// File: rtl/or1200_debug_controller_if.sv
// Debug port bundle between the debug controller (peripheral side) and the
// or1200 processor wrapper (processor side).
interface debug #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     stall;
    logic                     ewt;
    logic                     stb;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0]    datI;
    logic [DATA_WIDTH-1:0]    datO;
    logic                     bp;
    logic                     ack;
    logic [3:0]               lss;
    logic [1:0]               is;
    logic [10:0]              wp;

    modport peripheral (
        output stall, ewt, stb, we, adr, datI,
        input  bp, ack, datO, lss, is, wp
    );

    modport processor (
        input  stall, ewt, stb, we, adr, datI,
        output bp, ack, datO, lss, is, wp
    );
endinterface

// File: rtl/or1200_debug_controller.sv
// Debug-port master for the or1200: turns READ/WRITE/HALT/RESUME commands into
// stall/strobe sequences on the debug interface and returns one response each.
module or1200_debug_controller #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    debug.peripheral                 debugInterface,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err,
    output logic                     halted,
    output logic                     halt_evt,
    output logic [1:0]               state_dbg
);
    // Handshakes: a command transfers on a rising edge with cmd_valid & cmd_ready;
    // a response transfers on a rising edge with resp_valid & resp_ready, and
    // resp_valid/resp_data/resp_err hold steady until then.
    typedef enum logic [1:0] {IDLE, SETTLE, STROBE, RESP} state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_MAX = 16'(ACK_TIMEOUT - 1);

    state_t                   state;
    logic [1:0]               op_q;
    logic                     auto_stall;
    logic                     stb_q;
    logic                     we_q;
    logic                     bp_q;
    logic [ADDRESS_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0]    dat_q;
    logic [7:0]               settle_cnt;
    logic [15:0]              timeout_cnt;
    logic                     bp_rise;
    logic                     unused_dbg;

    assign bp_rise    = debugInterface.bp & ~bp_q;
    assign unused_dbg = ^{debugInterface.lss, debugInterface.is, debugInterface.wp};

    assign debugInterface.stall = halted | auto_stall;
    assign debugInterface.ewt   = 1'b0;
    assign debugInterface.stb   = stb_q;
    assign debugInterface.we    = we_q;
    assign debugInterface.adr   = adr_q;
    assign debugInterface.datI  = dat_q;
    assign state_dbg            = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            auto_stall  <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            bp_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            cmd_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            halted      <= 1'b0;
            halt_evt    <= 1'b0;
        end else begin
            bp_q     <= debugInterface.bp;
            halt_evt <= bp_rise;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        adr_q     <= cmd_addr;
                        dat_q     <= cmd_data;
                        case (cmd_op)
                            OP_HALT, OP_RESUME: begin
                                halted     <= (cmd_op == OP_HALT);
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b0;
                                resp_data  <= '0;
                                state      <= RESP;
                            end
                            default: begin
                                timeout_cnt <= '0;
                                if (halted) begin
                                    stb_q <= 1'b1;
                                    we_q  <= (cmd_op == OP_WRITE);
                                    state <= STROBE;
                                end else begin
                                    auto_stall <= 1'b1;
                                    settle_cnt <= SETTLE_LOAD;
                                    state      <= SETTLE;
                                end
                            end
                        endcase
                    end
                end
                // Stall has been asserted since acceptance; the counter
                // lets the pipeline drain before the first strobe.
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        stb_q       <= 1'b1;
                        we_q        <= (op_q == OP_WRITE);
                        timeout_cnt <= '0;
                        state       <= STROBE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (debugInterface.ack) begin
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= (op_q == OP_READ) ? debugInterface.datO : '0;
                        state      <= RESP;
                    end else if (timeout_cnt >= TIMEOUT_MAX) begin
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                        state      <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        auto_stall <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A breakpoint edge wins over a RESUME accepted in the same cycle.
            if (bp_rise) begin
                halted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_or1200_debug_controller.sv
// Self-checking bench for or1200_debug_controller with a small processor-side
// ack model and a response scoreboard.
module tb_or1200_debug_controller;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        halted;
    logic        halt_evt;
    logic [1:0]  state_dbg;

    debug #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dbg_if ();

    or1200_debug_controller #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .SETTLE_CYCLES(4),
        .ACK_TIMEOUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .debugInterface(dbg_if),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .halted(halted),
        .halt_evt(halt_evt),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int resp_cnt = 0;
    int n_expected = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- processor ack model ----------------
    bit          ack_never = 1'b0;
    int          ack_lat   = 0;
    logic [31:0] rd_data   = 32'h0;
    int          stb_cyc   = 0;

    always @(posedge clock) begin
        #1;
        if (!reset || !dbg_if.stb) stb_cyc = 0;
        else stb_cyc++;
        dbg_if.ack  = !ack_never && dbg_if.stb && (stb_cyc == ack_lat + 1);
        dbg_if.datO = rd_data;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [32:0] e;
        if (reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'd0, resp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", resp_err, e[32]);
                check("resp_data", resp_data, e[31:0]);
                resp_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input bit expect_resp, input logic exp_err, input logic [31:0] exp_data);
        int n;
        bit seen;
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clock);
            if (cmd_ready) seen = 1'b1;
            n++;
        end
        if (!seen) check("cmd_accept", cmd_ready, 1);
        if (expect_resp) begin
            exp_q.push_back({exp_err, exp_data});
            n_expected++;
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) check("resp_wait", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_stb;
        int stb_count;
        int evt_cnt;
        bit stable;
        bit seen;
        logic [31:0] snap;

        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_addr   = 32'h0;
        cmd_data   = 32'h0;
        resp_ready = 1'b1;
        dbg_if.bp  = 1'b0;
        dbg_if.lss = 4'h0;
        dbg_if.is  = 2'h0;
        dbg_if.wp  = 11'h0;

        // reset values
        repeat (3) @(negedge clock);
        check("rst_stall", dbg_if.stall, 0);
        check("rst_stb", dbg_if.stb, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_adr", dbg_if.adr, 0);
        check("rst_resp_data", resp_data, 0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("post_rst_ready", cmd_ready, 1);

        // async reset mid-strobe drops the access with no response
        ack_never = 1'b1;
        send_cmd(OP_READ, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (dbg_if.stb) seen = 1'b1;
        end
        check("rst_pre_stb", dbg_if.stb, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_stb", dbg_if.stb, 0);
        check("rst_async_stall", dbg_if.stall, 0);
        check("rst_async_resp_valid", resp_valid, 0);
        @(negedge clock); reset = 1'b1; ack_never = 1'b0;
        @(posedge clock); @(negedge clock);
        check("rst_release_ready", cmd_ready, 1);
        repeat (5) @(negedge clock);
        check("rst_no_resp", resp_valid, 0);

        // HALT then READ with ack one cycle after strobe
        send_cmd(OP_HALT, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        wait_resp();
        check("halt_halted", halted, 1);
        ack_lat = 1;
        rd_data = 32'hDEAD_BEEF;
        send_cmd(OP_READ, 32'h3000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clock);
        check("hrd_stall", dbg_if.stall, 1);
        check("hrd_stb", dbg_if.stb, 1);
        check("hrd_adr", dbg_if.adr, 32'h3000_0010);
        check("hrd_we", dbg_if.we, 0);
        wait_resp();
        @(negedge clock);
        check("hrd_halted_after", halted, 1);
        check("hrd_stall_after", dbg_if.stall, 1);

        // latency while halted, ack in first strobe cycle
        ack_lat = 0;
        rd_data = 32'h1111_2222;
        send_cmd(OP_READ, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1111_2222);
        @(negedge clock);
        check("lat_c1_stb", dbg_if.stb, 1);
        check("lat_c1_resp_valid", resp_valid, 0);
        @(negedge clock);
        check("lat_c2_resp_valid", resp_valid, 1);
        check("lat_c2_stb", dbg_if.stb, 0);
        check("lat_c2_cmd_ready", cmd_ready, 0);
        @(negedge clock);
        check("lat_c3_cmd_ready", cmd_ready, 1);
        wait_resp();

        // ack timeout while halted
        ack_never = 1'b1;
        rd_data = 32'h5555_AAAA;
        send_cmd(OP_READ, 32'h24, 32'h0, 1'b1, 1'b1, 32'h0);
        stb_count = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (dbg_if.stb) stb_count++;
        end
        check("to_stb_cycles", stb_count, 8);
        wait_resp();
        ack_never = 1'b0;

        // response held while resp_ready is low
        rd_data = 32'hA5A5_5A5A;
        @(posedge clock); #1; resp_ready = 1'b0;
        send_cmd(OP_READ, 32'h28, 32'h0, 1'b1, 1'b0, 32'hA5A5_5A5A);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        check("hold_resp_seen", resp_valid, 1);
        snap = resp_data;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (!resp_valid || resp_data !== snap || cmd_ready) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_data", snap, 32'hA5A5_5A5A);
        @(posedge clock); #1; resp_ready = 1'b1;
        wait_resp();

        // RESUME, then auto-stalled WRITE
        send_cmd(OP_RESUME, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        wait_resp();
        @(negedge clock);
        check("resume_halted", halted, 0);
        check("resume_stall", dbg_if.stall, 0);
        ack_lat = 0;
        send_cmd(OP_WRITE, 32'h10, 32'h1234, 1'b1, 1'b0, 32'h0);
        first_stb = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c == 1) check("wr_stall_c1", dbg_if.stall, 1);
            if (c == 4) check("wr_stall_c4", dbg_if.stall, 1);
            if (dbg_if.stb && first_stb == 0) begin
                first_stb = c;
                check("wr_we", dbg_if.we, 1);
                check("wr_adr", dbg_if.adr, 32'h10);
                check("wr_datI", dbg_if.datI, 32'h1234);
            end
            if (c == 10) check("wr_stall_after", dbg_if.stall, 0);
        end
        check("wr_first_stb_cycle", first_stb, 5);
        wait_resp();

        // breakpoint pulse of 3 cycles while running
        @(posedge clock); #1; dbg_if.bp = 1'b1;
        evt_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (halt_evt) evt_cnt++;
            if (i == 0) check("bp_halted_c0", halted, 0);
            if (i == 1) begin
                check("bp_halted_c1", halted, 1);
                check("bp_stall_c1", dbg_if.stall, 1);
            end
            @(posedge clock); #1;
            if (i == 2) dbg_if.bp = 1'b0;
        end
        check("bp_evt_count", evt_cnt, 1);

        // RESUME accepted with a bp rising edge in the same cycle
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_op = OP_RESUME; dbg_if.bp = 1'b1;
        exp_q.push_back({1'b0, 32'h0});
        n_expected++;
        @(negedge clock);
        check("rbp_ready", cmd_ready, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0; dbg_if.bp = 1'b0;
        @(negedge clock);
        check("rbp_halted", halted, 1);
        check("rbp_evt", halt_evt, 1);
        wait_resp();

        // bp during an auto-stalled access keeps stall after the response
        send_cmd(OP_RESUME, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        wait_resp();
        ack_lat = 2;
        rd_data = 32'h0BAD_F00D;
        send_cmd(OP_READ, 32'h44, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D);
        @(posedge clock); #1; dbg_if.bp = 1'b1;
        @(posedge clock); #1; dbg_if.bp = 1'b0;
        wait_resp();
        @(negedge clock);
        check("abp_halted", halted, 1);
        check("abp_stall", dbg_if.stall, 1);

        // final report
        repeat (3) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        check("resp_count", resp_cnt, n_expected);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
